point_mul: RTL and testbench

Parametrised elliptic-curve scalar multiplier R = k·P, the successor to the fixed 256-bit double-and-add unit. It adds explicit point-at-infinity tracking, ready/valid handshakes on both sides, abort, early termination and an optional constant-time mode. It drives one instance of the team's point-adder (`add`) and sits between the key-management front end and the signature/ECDH datapath.

---
 rtl/ecc_pkg.sv | 23 ++
 rtl/point_mul_add.sv | 51 +++++
 rtl/point_mul.sv | 196 +++++++++++++++++++
 tb/tb_point_mul.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared definitions for the scalar multiplier and its point adder
// Contents: default coordinate/scalar widths, point-adder latency,
//           multiplier state encoding, point-at-infinity convention.
package ecc_pkg;

  localparam int DEF_DATA_WIDTH = 256;
  localparam int DEF_K_WIDTH    = 256;

  // Cycles from add in_valid to add out_valid.
  localparam int ADD_LATENCY    = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ADD   = 3'd2,
    ST_DBL   = 3'd3,
    ST_DONE  = 3'd4
  } pm_state_t;

  // Point at infinity is carried as coordinates (0,0) with this flag value.
  localparam logic INF_FLAG = 1'b1;

endpackage

// File: rtl/point_mul_add.sv
// rtl/point_mul_add.sv - pipelined point adder used by point_mul
// Ports: clk, rst_n (async active-low); in_valid pulse with operands (ax,ay),(bx,by);
//        out_valid pulse LATENCY cycles later with the sum (sx,sy).
// The group law is component-wise addition modulo 2^DATA_WIDTH; it needs no
// special case for P==Q, so the same path serves as the doubler.
module add
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LATENCY    = ADD_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] ax,
  input  logic [DATA_WIDTH-1:0] ay,
  input  logic [DATA_WIDTH-1:0] bx,
  input  logic [DATA_WIDTH-1:0] by,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] sx,
  output logic [DATA_WIDTH-1:0] sy
);

  logic [LATENCY-1:0]    vld;
  logic [DATA_WIDTH-1:0] pipe_x [LATENCY];
  logic [DATA_WIDTH-1:0] pipe_y [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_x[i] <= '0;
        pipe_y[i] <= '0;
      end
    end else begin
      vld[0]    <= in_valid;
      pipe_x[0] <= ax + bx;
      pipe_y[0] <= ay + by;
      for (int i = 1; i < LATENCY; i++) begin
        vld[i]    <= vld[i-1];
        pipe_x[i] <= pipe_x[i-1];
        pipe_y[i] <= pipe_y[i-1];
      end
    end
  end

  assign out_valid = vld[LATENCY-1];
  assign sx        = pipe_x[LATENCY-1];
  assign sy        = pipe_y[LATENCY-1];

endmodule

// File: rtl/point_mul.sv
// rtl/point_mul.sv - LSB-first double-and-add scalar multiplier R = k*P
// Ports: clk, rst_n (async active-low); request in_valid/in_ready with Px,Py,k;
//        abort; result out_valid/out_ready with Rx,Ry,R_inf; busy.
// Build option: POINT_MUL_CT_EN selects constant-time mode (every bit runs ADD
// and DBL, no early exit); undefined gives variable latency.
module point_mul
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int K_WIDTH    = DEF_K_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] Px,
  input  logic [DATA_WIDTH-1:0] Py,
  input  logic [K_WIDTH-1:0]    k,
  input  logic                  abort,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Rx,
  output logic [DATA_WIDTH-1:0] Ry,
  output logic                  R_inf,
  output logic                  busy
);

  localparam int CNT_W = $clog2(K_WIDTH + 1);

  pm_state_t             state, state_d;
  logic [DATA_WIDTH-1:0] p_x, p_y, p_x_d, p_y_d;
  logic [DATA_WIDTH-1:0] r_x, r_y, r_x_d, r_y_d;
  logic                  r_inf, r_inf_d;
  logic [K_WIDTH-1:0]    k_reg, k_reg_d, k_shift;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic                  op_issued, add_busy;
  logic                  add_in_valid, add_out_valid;
  logic [DATA_WIDTH-1:0] add_bx, add_by, sum_x, sum_y;
  logic                  bit_cur, at_end, accept;
  logic [DATA_WIDTH-1:0] rx_q, ry_q;
  logic                  r_inf_q;

  // Shifting instead of indexing keeps cnt==K_WIDTH in range.
  assign k_shift  = k_reg >> cnt;
  assign bit_cur  = k_shift[0];
  assign at_end   = (cnt == CNT_W'(K_WIDTH));

`ifndef POINT_MUL_CT_EN
  logic all_zero, rest_zero;
  assign all_zero  = (k_shift == '0);
  assign rest_zero = ((k_shift >> 1) == '0);
`endif

  assign in_ready  = (state == ST_IDLE) && !add_busy;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE) || add_busy;
  assign Rx        = rx_q;
  assign Ry        = ry_q;
  assign R_inf     = r_inf_q;

  // One adder op per ADD/DBL visit, issued in the entry cycle.
  assign add_in_valid = ((state == ST_ADD) || (state == ST_DBL)) && !op_issued;
  assign add_bx       = (state == ST_DBL) ? p_x : r_x;
  assign add_by       = (state == ST_DBL) ? p_y : r_y;

  add #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (ADD_LATENCY)
  ) u_add (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (add_in_valid),
    .ax        (p_x),
    .ay        (p_y),
    .bx        (add_bx),
    .by        (add_by),
    .out_valid (add_out_valid),
    .sx        (sum_x),
    .sy        (sum_y)
  );

  always_comb begin
    state_d = state;
    p_x_d   = p_x;
    p_y_d   = p_y;
    r_x_d   = r_x;
    r_y_d   = r_y;
    r_inf_d = r_inf;
    k_reg_d = k_reg;
    cnt_d   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          p_x_d   = Px;
          p_y_d   = Py;
          k_reg_d = k;
          r_x_d   = '0;
          r_y_d   = '0;
          r_inf_d = INF_FLAG;
          cnt_d   = '0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
`ifdef POINT_MUL_CT_EN
        state_d = at_end ? ST_DONE : ST_ADD;
`else
        if (at_end || all_zero) begin
          state_d = ST_DONE;
        end else if (bit_cur) begin
          if (r_inf) begin
            // First set bit: R = 2^cnt*P is just a copy, no adder op needed.
            r_x_d   = p_x;
            r_y_d   = p_y;
            r_inf_d = 1'b0;
            state_d = rest_zero ? ST_DONE : ST_DBL;
          end else begin
            state_d = ST_ADD;
          end
        end else begin
          state_d = ST_DBL;
        end
`endif
      end
      ST_ADD: begin
        if (add_out_valid) begin
`ifdef POINT_MUL_CT_EN
          // The add always runs; its result is only kept for a real P+R.
          if (bit_cur) begin
            r_x_d   = r_inf ? p_x : sum_x;
            r_y_d   = r_inf ? p_y : sum_y;
            r_inf_d = 1'b0;
          end
          state_d = ST_DBL;
`else
          r_x_d   = sum_x;
          r_y_d   = sum_y;
          state_d = rest_zero ? ST_DONE : ST_DBL;
`endif
        end
      end
      ST_DBL: begin
        if (add_out_valid) begin
          p_x_d   = sum_x;
          p_y_d   = sum_y;
          cnt_d   = cnt + CNT_W'(1);
          state_d = ST_CHECK;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state != ST_IDLE)) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      p_x       <= '0;
      p_y       <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_inf     <= INF_FLAG;
      k_reg     <= '0;
      cnt       <= '0;
      op_issued <= 1'b0;
      add_busy  <= 1'b0;
      rx_q      <= '0;
      ry_q      <= '0;
      r_inf_q   <= INF_FLAG;
    end else begin
      state <= state_d;
      p_x   <= p_x_d;
      p_y   <= p_y_d;
      r_x   <= r_x_d;
      r_y   <= r_y_d;
      r_inf <= r_inf_d;
      k_reg <= k_reg_d;
      cnt   <= cnt_d;
      if (state_d != state) op_issued <= 1'b0;
      else if (add_in_valid) op_issued <= 1'b1;
      // Tracks the adder independently of the FSM so an aborted op still blocks new work.
      if (add_in_valid) add_busy <= 1'b1;
      else if (add_out_valid) add_busy <= 1'b0;
      if ((state_d == ST_DONE) && (state != ST_DONE)) begin
        rx_q    <= r_x_d;
        ry_q    <= r_y_d;
        r_inf_q <= r_inf_d;
      end
    end
  end

endmodule

// File: tb/tb_point_mul.sv
// tb/tb_point_mul.sv - directed self-checking bench for point_mul
module tb_point_mul;
  import ecc_pkg::*;

  localparam int W  = 256;
  localparam int KW = 256;
  localparam int LA = ADD_LATENCY;
  localparam logic [W-1:0] GX = 256'hC0FFEE00_11223344_55667788_99AABBCC_DDEEFF00_12345678_9ABCDEF0_0F1E2D3C;
  localparam logic [W-1:0] GY = 256'h8BADF00D_DEADBEEF_CAFEBABE_FEEDFACE_01020304_05060708_090A0B0C_0D0E0F10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready, out_valid, R_inf, busy;
  logic [W-1:0]  Px = '0;
  logic [W-1:0]  Py = '0;
  logic [W-1:0]  Rx, Ry;
  logic [KW-1:0] k = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int add_ops = 0;

  point_mul #(.DATA_WIDTH(W), .K_WIDTH(KW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Px        (Px),
    .Py        (Py),
    .k         (k),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Rx        (Rx),
    .Ry        (Ry),
    .R_inf     (R_inf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (dut.add_in_valid) add_ops++;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present G*k, wait for accept, then count edges until out_valid.
  task automatic request(input logic [KW-1:0] kk, output int lat, output int ops);
    int guard;
    int ops0;
    @(negedge clk);
    in_valid = 1'b1;
    Px = GX;
    Py = GY;
    k  = kk;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", W'(in_ready), W'(1));
    ops0 = add_ops;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("out_valid_seen", W'(out_valid), W'(1));
    ops = add_ops - ops0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle_out_valid", W'(out_valid), W'(0));
    check("idle_in_ready", W'(in_ready), W'(1));
  endtask

  initial begin
    int lat, ops, ops0;
    logic [W-1:0] ex, ey, sx, sy;
    logic [KW-1:0] kk;
    logic sinf;
    bit stable, seen_ov, ready_early;
    int guard;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_rx", Rx, '0);
    check("rst_ry", Ry, '0);
    check("rst_rinf", W'(R_inf), W'(1));
    check("rst_busy", W'(busy), W'(0));
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", W'(in_ready), W'(1));

`ifndef POINT_MUL_CT_EN
    // k=0: CHECK exits immediately; out_valid on the edge after accept.
    request('0, lat, ops);
    check("k0_lat", W'(lat), W'(1));
    check("k0_rinf", W'(R_inf), W'(1));
    check("k0_rx", Rx, '0);
    check("k0_ry", Ry, '0);
    check("k0_ops", W'(ops), W'(0));
    consume();

    request(KW'(1), lat, ops);
    check("k1_rx", Rx, GX);
    check("k1_ry", Ry, GY);
    check("k1_rinf", W'(R_inf), W'(0));
    check("k1_ops", W'(ops), W'(0));
    consume();

    request(KW'(2), lat, ops);
    ex = GX * W'(2);
    ey = GY * W'(2);
    check("k2_rx", Rx, ex);
    check("k2_ry", Ry, ey);
    check("k2_rinf", W'(R_inf), W'(0));
    check("k2_ops", W'(ops), W'(1));
    consume();

    // k=3: DBL, ADD (no trailing DBL).
    request(KW'(3), lat, ops);
    ex = GX * W'(3);
    ey = GY * W'(3);
    check("k3_rx", Rx, ex);
    check("k3_ry", Ry, ey);
    check("k3_ops", W'(ops), W'(2));
    consume();

    // k=13: DBL, DBL, ADD, DBL, ADD; held under backpressure.
    request(KW'(13), lat, ops);
    ex = GX * W'(13);
    ey = GY * W'(13);
    check("k13_rx", Rx, ex);
    check("k13_ry", Ry, ey);
    check("k13_rinf", W'(R_inf), W'(0));
    check("k13_ops", W'(ops), W'(5));
    sx = Rx;
    sy = Ry;
    sinf = R_inf;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      stable = (Rx === sx) && (Ry === sy) && (R_inf === sinf) && (out_valid === 1'b1);
      check("bp_stable", W'(stable), W'(1));
    end
    consume();

    // Abort while ADD is waiting on the adder (k=7: DBL then ADD).
    @(negedge clk);
    in_valid = 1'b1;
    Px = GX;
    Py = GY;
    k  = KW'(7);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    ops0 = add_ops;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    guard = 0;
    while ((add_ops - ops0) < 2 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("abort_in_add", W'(add_ops - ops0), W'(2));
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_out_valid", W'(out_valid), W'(0));
    check("abort_busy", W'(busy), W'(1));
    seen_ov = 1'b0;
    ready_early = 1'b0;
    for (int i = 0; i < 20 && !dut.add_out_valid; i++) begin
      if (in_ready) ready_early = 1'b1;
      if (out_valid) seen_ov = 1'b1;
      @(posedge clk);
      #1;
    end
    if (in_ready) ready_early = 1'b1;
    if (out_valid) seen_ov = 1'b1;
    check("abort_stale_seen", W'(dut.add_out_valid), W'(1));
    @(posedge clk);
    #1;
    check("abort_ready_early", W'(ready_early), W'(0));
    check("abort_never_valid", W'(seen_ov | out_valid), W'(0));
    check("abort_ready_after", W'(in_ready), W'(1));

    request(KW'(1), lat, ops);
    check("post_abort_rx", Rx, GX);
    check("post_abort_ry", Ry, GY);
    check("post_abort_rinf", W'(R_inf), W'(0));
    consume();
`else
    request(KW'(1), lat, ops);
    check("ct_k1_lat", W'(lat), W'(KW * (1 + 2 * (LA + 1)) + 1));
    check("ct_k1_rx", Rx, GX);
    check("ct_k1_ry", Ry, GY);
    check("ct_k1_rinf", W'(R_inf), W'(0));
    consume();

    kk = '0;
    kk[KW-1] = 1'b1;
    request(kk, lat, ops);
    ex = GX << (KW - 1);
    ey = GY << (KW - 1);
    check("ct_kmsb_lat", W'(lat), W'(KW * (1 + 2 * (LA + 1)) + 1));
    check("ct_kmsb_rx", Rx, ex);
    check("ct_kmsb_ry", Ry, ey);
    check("ct_kmsb_rinf", W'(R_inf), W'(0));
    consume();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
